// File: rtl/mult_wallace_6to3.sv
// mult_wallace_6to3
//   Registered 6:3 Wallace counter. Counts the ones among six equal-weight
//   input bits and presents the count as {CO,S2,S1}, registered once so
//   that compressor tree levels can be stacked one level per clock.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   A1..A6 carry a valid operand this cycle
//   A1..A6     in   six bits of weight 1
//   out_valid  out  registered result is valid
//   S1         out  count bit 0 (weight 1)
//   S2         out  count bit 1 (weight 2)
//   CO         out  count bit 2 (weight 4)
module mult_wallace_6to3 (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic A1,
   input  logic A2,
   input  logic A3,
   input  logic A4,
   input  logic A5,
   input  logic A6,
   output logic out_valid,
   output logic S1,
   output logic S2,
   output logic CO
);

   function automatic logic fa_sum(input logic x, input logic y, input logic z);
      return x ^ y ^ z;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   logic sa, ca, sb, cb, cc;
   logic s1_d, s2_d, co_d;
   logic s1_q, s2_q, co_q, valid_q;

   // Level 1: two full adders reduce six weight-1 bits to two w1 + two w2.
   assign sa = fa_sum  (A1, A2, A3);
   assign ca = fa_carry(A1, A2, A3);
   assign sb = fa_sum  (A4, A5, A6);
   assign cb = fa_carry(A4, A5, A6);

   // Level 2: half adder closes weight 1, its carry joins the weight-2 column.
   assign s1_d = sa ^ sb;
   assign cc   = sa & sb;

   // Level 3: weight-2 column of three bits; at most one of ca/cb/cc pairs
   // can combine with another such that the total never exceeds 6.
   assign s2_d = fa_sum  (ca, cb, cc);
   assign co_d = fa_carry(ca, cb, cc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         co_q    <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            co_q <= co_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign S1        = s1_q;
   assign S2        = s2_q;
   assign CO        = co_q;

endmodule

// File: tb/tb_mult_wallace_6to3.sv
module tb_mult_wallace_6to3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic A1 = 1'b0, A2 = 1'b0, A3 = 1'b0, A4 = 1'b0, A5 = 1'b0, A6 = 1'b0;
   logic out_valid, S1, S2, CO;

   int n_cmp = 0;
   int n_bad = 0;
   logic [2:0] exp_cnt = 3'd0;
   logic       exp_vld = 1'b0;
   logic       chk_en  = 1'b0;

   mult_wallace_6to3 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .A1       (A1),
      .A2       (A2),
      .A3       (A3),
      .A4       (A4),
      .A5       (A5),
      .A6       (A6),
      .out_valid(out_valid),
      .S1       (S1),
      .S2       (S2),
      .CO       (CO)
   );

   always #5 clk = ~clk;

   // Reference: the output is simply the ones-count of the last valid operand.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_cnt <= 3'd0;
         exp_vld <= 1'b0;
      end else begin
         exp_vld <= in_valid;
         if (in_valid) exp_cnt <= 3'($countones({A1, A2, A3, A4, A5, A6}));
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got {vld,cnt}=%b required %b at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (chk_en) check("model", {out_valid, CO, S2, S1}, {exp_vld, exp_cnt});
   end

   task automatic drive(input logic v, input logic [5:0] a);
      in_valid = v;
      {A1, A2, A3, A4, A5, A6} = a;
   endtask

   // Apply one operand at the falling edge, return 2 time units after the capturing edge.
   task automatic step(input logic v, input logic [5:0] a);
      @(negedge clk);
      drive(v, a);
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [2:0] spot;
      #1;
      check("reset_initial", {out_valid, CO, S2, S1}, 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Exhaustive sweep with literal spot values.
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 6'(i));
         spot = 3'bxxx;
         case (i)
            0:  spot = 3'b000;
            1:  spot = 3'b001;
            3:  spot = 3'b010;
            7:  spot = 3'b011;
            31: spot = 3'b101;
            63: spot = 3'b110;
            default: ;
         endcase
         if (i == 0 || i == 1 || i == 3 || i == 7 || i == 31 || i == 63)
            check($sformatf("spot_%0d", i), {out_valid, CO, S2, S1}, {1'b1, spot});
      end

      // Hold: invalid operand must not load.
      step(1'b1, 6'b101010);
      check("hold_load", {out_valid, CO, S2, S1}, 4'b1011);
      step(1'b0, 6'b111111);
      check("hold_keep", {out_valid, CO, S2, S1}, 4'b0011);

      // Back-to-back.
      step(1'b1, 6'b111111);
      check("b2b_first", {out_valid, CO, S2, S1}, 4'b1110);
      step(1'b1, 6'b000000);
      check("b2b_second", {out_valid, CO, S2, S1}, 4'b1000);

      // Symmetry: three ones in varied positions.
      step(1'b1, 6'b100101);
      check("sym_100101", {out_valid, CO, S2, S1}, 4'b1011);
      step(1'b1, 6'b011010);
      check("sym_011010", {out_valid, CO, S2, S1}, 4'b1011);
      step(1'b1, 6'b110001);
      check("sym_110001", {out_valid, CO, S2, S1}, 4'b1011);

      // Asynchronous reset mid-cycle while holding 6.
      step(1'b1, 6'b111111);
      check("pre_reset6", {out_valid, CO, S2, S1}, 4'b1110);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", {out_valid, CO, S2, S1}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-stream: operand present across a reset edge is discarded.
      step(1'b1, 6'b110000);
      check("pre_midrst", {out_valid, CO, S2, S1}, 4'b1010);
      @(negedge clk);
      drive(1'b1, 6'b110000);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      check("midrst_hold", {out_valid, CO, S2, S1}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 6'b110000);
      @(posedge clk);
      #2;
      check("midrst_after", {out_valid, CO, S2, S1}, 4'b0000);
      step(1'b0, 6'b111111);
      check("midrst_idle", {out_valid, CO, S2, S1}, 4'b0000);
      step(1'b1, 6'b010000);
      check("midrst_next", {out_valid, CO, S2, S1}, 4'b1001);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 3) != 0), 6'($urandom));
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
